// File: rtl/cpu_uart_tx_pkg.sv
// Shared UART TX types: FSM state, register bundle, reset helper.
// Imported by cpu_uart_tx and uart_tx_fifo.
package lib_uart;

  localparam int UART_DATA_BITS = 8;
  localparam int CLK_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } TX_STATE;

  typedef struct packed {
    TX_STATE                     state;
    logic [2:0]                  bit_cnt;
    logic [CLK_CNT_W-1:0]        clk_cnt;
    logic [UART_DATA_BITS-1:0]   shreg;
    logic                        tx;
    logic                        busy;
  } TX_REGS;

  function automatic TX_REGS tx_regs_reset();
    TX_REGS r;
    r.state   = IDLE;
    r.bit_cnt = '0;
    r.clk_cnt = '0;
    r.shreg   = '0;
    r.tx      = 1'b1;
    r.busy    = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO in front of the TX FSM.
// Ports: push/wdata in, pop/rdata out, full/empty flags.
module uart_tx_fifo
  import lib_uart::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] wdata,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] rdata,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               cnt;
  logic                      do_push;
  logic                      do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cpu_uart_tx.sv
// UART 8N1 transmitter on the CPU write port; w_busy gates requests.
// Ports: w_req/w_data in, w_busy/uart_tx/frame_done out. Option: CPU_UART_TX_FIFO_EN.
module cpu_uart_tx
  import lib_uart::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_req,
  input  logic [31:0] w_data,
  output logic        w_busy,
  output logic        uart_tx,
  output logic        frame_done
);

  localparam logic [CLK_CNT_W-1:0] LAST_CNT =
    CLK_CNT_W'(CLKS_PER_BIT - 1);

  TX_REGS                    r;
  TX_REGS                    r_nxt;
  logic                      load;
  logic [UART_DATA_BITS-1:0] load_byte;
  logic                      last;
  logic                      unused_hi;

  assign unused_hi = ^w_data[31:8];

`ifdef CPU_UART_TX_FIFO_EN
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_rdata;

  // busy is the registered occupancy, so a push in the pop cycle
  // still sees the pre-pop fullness.
  assign fifo_push = w_req & ~fifo_full;
  assign fifo_pop  = (r.state == IDLE) & ~fifo_empty;
  assign load      = fifo_pop;
  assign load_byte = fifo_rdata;
  assign w_busy    = fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (w_data[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  assign load      = w_req & ~r.busy;
  assign load_byte = w_data[7:0];
  assign w_busy    = r.busy;
`endif

  assign last       = (r.clk_cnt == LAST_CNT);
  assign uart_tx    = r.tx;
  assign frame_done = (r.state == STOP) & last;

  // tx is registered, so each branch drives the level of the
  // state being entered.
  always_comb begin
    r_nxt = r;
    unique case (1'b1)
      (r.state == IDLE): begin
        if (load) begin
          r_nxt.state   = START;
          r_nxt.clk_cnt = '0;
          r_nxt.bit_cnt = '0;
          r_nxt.shreg   = load_byte;
          r_nxt.tx      = 1'b0;
          r_nxt.busy    = 1'b1;
        end
      end
      (r.state == START): begin
        if (last) begin
          r_nxt.state   = DATA;
          r_nxt.clk_cnt = '0;
          r_nxt.tx      = r.shreg[0];
        end else begin
          r_nxt.clk_cnt = r.clk_cnt + CLK_CNT_W'(1);
        end
      end
      (r.state == DATA): begin
        if (last) begin
          r_nxt.clk_cnt = '0;
          r_nxt.bit_cnt = r.bit_cnt + 3'd1;
          r_nxt.shreg   = r.shreg >> 1;
          if (r.bit_cnt == 3'd7) begin
            r_nxt.state = STOP;
            r_nxt.tx    = 1'b1;
          end else begin
            r_nxt.tx    = r.shreg[1];
          end
        end else begin
          r_nxt.clk_cnt = r.clk_cnt + CLK_CNT_W'(1);
        end
      end
      (r.state == STOP): begin
        if (last) begin
          r_nxt.state   = IDLE;
          r_nxt.clk_cnt = '0;
          r_nxt.tx      = 1'b1;
          r_nxt.busy    = 1'b0;
        end else begin
          r_nxt.clk_cnt = r.clk_cnt + CLK_CNT_W'(1);
        end
      end
      default: r_nxt = tx_regs_reset();
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r <= tx_regs_reset();
    else        r <= r_nxt;
  end

endmodule
